// File: rtl/fdma_axi_wr.sv
// fdma_axi_wr: write-side FDMA engine turning (address, beat count) requests into AXI4 INCR write bursts.
// Ports: ui_clk/ui_rstn (async active-low reset); fdma_* request/busy handshake and FWFT FIFO pop
// interface (fdma_wdata head, fdma_wready available, fdma_wvalid pop); wr_err sticky error on any
// failing BRESP; m_axi_aw*/w*/b* AXI4 write master with one burst outstanding at a time.
// Optional macro FDMA_W_4K_SPLIT_EN: also split bursts at 4 KB boundaries.
module fdma_axi_wr #(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BURST_LEN  = 256,
  parameter int AXI_ID         = 0
) (
  input  logic                        ui_clk,
  input  logic                        ui_rstn,
  input  logic [AXI_ADDR_WIDTH-1:0]   fdma_waddr,
  input  logic                        fdma_wareq,
  input  logic [15:0]                 fdma_wsize,
  output logic                        fdma_wbusy,
  input  logic [AXI_DATA_WIDTH-1:0]   fdma_wdata,
  output logic                        fdma_wvalid,
  input  logic                        fdma_wready,
  output logic                        wr_err,
  output logic [3:0]                  m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready
);
  localparam int BPB = AXI_DATA_WIDTH / 8;
  localparam int LSB = $clog2(BPB);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BPB - 1);
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B} state_t;
  state_t state, state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [15:0] remaining;
  logic [8:0] len, len_nxt, beat_cnt;
  logic last_beat;
`ifdef FDMA_W_4K_SPLIT_EN
  logic [12:0] beats_to_4k;
`endif
  assign m_axi_awid    = 4'(AXI_ID);
  assign m_axi_awsize  = 3'(LSB);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = fdma_wdata;
  // Burst length: remaining beats capped by MAX_BURST_LEN (and by the 4 KB page when enabled).
  // When remaining is below the cap it fits in 9 bits, so the narrow slice is exact.
  always_comb begin
    len_nxt = (remaining >= 16'(MAX_BURST_LEN)) ? 9'(MAX_BURST_LEN) : remaining[8:0];
`ifdef FDMA_W_4K_SPLIT_EN
    beats_to_4k = 13'((13'h1000 - {1'b0, addr[11:0]}) >> LSB);
    len_nxt = ({4'd0, len_nxt} > beats_to_4k) ? beats_to_4k[8:0] : len_nxt;
`endif
  end
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) state <= S_IDLE;
    else          state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fdma_wareq) state_nxt = S_CALC;
      S_CALC:  state_nxt = (remaining == '0) ? S_IDLE : S_AW;
      S_AW:    if (m_axi_awready) state_nxt = S_W;
      S_W:     if (last_beat) state_nxt = S_B;
      S_B:     if (m_axi_bvalid) state_nxt = (remaining == {7'd0, len}) ? S_IDLE : S_CALC;
      default: state_nxt = S_IDLE;
    endcase
  end
  // W valid is the registered W state gated live by FIFO availability; a pop is an accepted beat.
  always_comb begin
    fdma_wbusy    = state != S_IDLE;
    m_axi_awvalid = state == S_AW;
    m_axi_wvalid  = (state == S_W) & fdma_wready;
    fdma_wvalid   = m_axi_wvalid & m_axi_wready;
    m_axi_wlast   = (state == S_W) & (beat_cnt == len - 9'd1);
    last_beat     = fdma_wvalid & m_axi_wlast;
    m_axi_bready  = state == S_B;
  end
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      addr         <= '0;
      remaining    <= '0;
      len          <= '0;
      beat_cnt     <= '0;
      m_axi_awaddr <= '0;
      m_axi_awlen  <= '0;
      wr_err       <= 1'b0;
    end else begin
      if (state == S_IDLE && fdma_wareq) begin
        addr      <= fdma_waddr & ALIGN_MASK;
        remaining <= fdma_wsize;
      end
      if (state == S_CALC && remaining != '0) begin
        len          <= len_nxt;
        beat_cnt     <= '0;
        m_axi_awaddr <= addr;
        m_axi_awlen  <= 8'(len_nxt - 9'd1);
      end
      if (fdma_wvalid) beat_cnt <= beat_cnt + 9'd1;
      // SLVERR/DECERR both have bit 1 set, i.e. bresp >= 2'b10.
      if (m_axi_bready && m_axi_bvalid) begin
        addr      <= addr + (AXI_ADDR_WIDTH'(len) << LSB);
        remaining <= remaining - {7'd0, len};
        wr_err    <= wr_err | (m_axi_bresp >= 2'b10);
      end
    end
  end
endmodule

// File: tb/tb_fdma_axi_wr.sv
// tb_fdma_axi_wr: randomized self-checking bench for fdma_axi_wr against a burst-list reference model.
module tb_fdma_axi_wr;
  logic ui_clk = 1'b0, ui_rstn = 1'b0;
  always #5 ui_clk = ~ui_clk;
  logic [31:0] fdma_waddr = '0;
  logic fdma_wareq = 1'b0;
  logic [15:0] fdma_wsize = '0;
  logic fdma_wbusy, fdma_wvalid, wr_err;
  logic fdma_wready = 1'b1;
  logic [127:0] fdma_wdata;
  logic [3:0] m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize;
  logic [1:0] m_axi_awburst;
  logic m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready;
  logic m_axi_awready = 1'b1, m_axi_wready = 1'b1, m_axi_bvalid = 1'b0;
  logic [127:0] m_axi_wdata;
  logic [15:0] m_axi_wstrb;
  logic [1:0] m_axi_bresp = 2'b00;

  fdma_axi_wr dut (
    .ui_clk(ui_clk), .ui_rstn(ui_rstn), .fdma_waddr(fdma_waddr), .fdma_wareq(fdma_wareq),
    .fdma_wsize(fdma_wsize), .fdma_wbusy(fdma_wbusy), .fdma_wdata(fdma_wdata),
    .fdma_wvalid(fdma_wvalid), .fdma_wready(fdma_wready), .wr_err(wr_err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  typedef struct packed {logic [31:0] a; logic [7:0] l;} aw_t;
  aw_t aw_q[$], exp_q[$];
  logic [127:0] pop_q[$];
  int wlast_q[$];
  int passed = 0, total = 0;
  int viol = 0, b_cnt = 0, aw_hs = 0, busy_cnt = 0, cyc = 0;
  int req_cyc = 0, first_aw_cyc = -1, b_last_cyc = 0, idle_cyc = 0, err_idx = -1;
  int unsigned src_idx = 0, src0 = 0;
  bit rnd = 0, pop_pend = 0, aw_pend = 0;
  logic [31:0] aw_prev_a;
  logic [7:0] aw_prev_l;

  // FIFO head content is a pure function of how many beats have been popped so far.
  function automatic logic [127:0] pat(input int unsigned i);
    return {i, i ^ 32'hDEAD_BEEF, i * 32'h9E37_79B9, ~i};
  endfunction
  assign fdma_wdata = pat(src_idx);

  // Reference: list of (address, awlen) the transfer should be cut into.
  function automatic void model(input logic [31:0] a, input int size);
    int n;
    int unsigned room;
    exp_q.delete();
    a &= ~32'hF;
    while (size > 0) begin
      n = (size < 256) ? size : 256;
      room = (4096 - (a % 4096)) / 16;
`ifdef FDMA_W_4K_SPLIT_EN
      if (room < n) n = room;
`endif
      exp_q.push_back({a, 8'(n - 1)});
      a += 32'(n * 16);
      size -= n;
    end
  endfunction

  function automatic int bursts_bad();
    int b = (aw_q.size() == exp_q.size()) ? 0 : 1;
    foreach (exp_q[i]) if (i >= aw_q.size() || aw_q[i] !== exp_q[i]) b++;
    return b;
  endfunction

  function automatic int data_bad();
    int b = 0;
    foreach (pop_q[i]) if (pop_q[i] !== pat(src0 + i)) b++;
    return b;
  endfunction

  function automatic int wlast_bad();
    int e[$];
    int s = -1;
    int b;
    foreach (exp_q[i]) begin
      s += int'(exp_q[i].l) + 1;
      e.push_back(s);
    end
    b = (e.size() == wlast_q.size()) ? 0 : 1;
    foreach (e[i]) if (i >= wlast_q.size() || wlast_q[i] != e[i]) b++;
    return b;
  endfunction

  // AXI slave + FIFO source driven just after posedge; bus observed at negedge.
  initial begin
    forever begin
      @(posedge ui_clk);
      #1;
      if (pop_pend) src_idx++;
      pop_pend = 0;
      fdma_wready   = rnd ? ($urandom % 4 != 0) : 1'b1;
      m_axi_wready  = rnd ? ($urandom % 3 != 0) : 1'b1;
      m_axi_awready = rnd ? 1'($urandom % 2) : 1'b1;
      m_axi_bvalid  = m_axi_bready && (!rnd || ($urandom % 2 == 0));
      m_axi_bresp   = (b_cnt == err_idx) ? 2'b10 : 2'b00;
      @(negedge ui_clk);
      cyc++;
      if (fdma_wbusy) busy_cnt++;
      if (fdma_wareq && !fdma_wbusy && ui_rstn) req_cyc = cyc;
      if (m_axi_awvalid && first_aw_cyc < 0) first_aw_cyc = cyc;
      if (fdma_wvalid !== (m_axi_wvalid & m_axi_wready)) viol++;
      if (m_axi_wvalid && !fdma_wready) viol++;
      if (m_axi_wdata !== fdma_wdata) viol++;
      if (m_axi_awvalid && aw_hs != b_cnt) viol++;
      if (aw_pend && (!m_axi_awvalid || m_axi_awaddr !== aw_prev_a || m_axi_awlen !== aw_prev_l)) viol++;
      aw_pend = m_axi_awvalid && !m_axi_awready;
      aw_prev_a = m_axi_awaddr;
      aw_prev_l = m_axi_awlen;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_q.push_back({m_axi_awaddr, m_axi_awlen});
        aw_hs++;
      end
      if (fdma_wvalid) begin
        if (m_axi_wlast) wlast_q.push_back(pop_q.size());
        pop_q.push_back(m_axi_wdata);
        pop_pend = 1;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_cnt++;
        b_last_cyc = cyc;
      end
    end
  end

  task automatic start(input logic [31:0] a, input int size);
    @(posedge ui_clk);
    #1;
    aw_q.delete(); pop_q.delete(); wlast_q.delete();
    viol = 0; b_cnt = 0; aw_hs = 0; busy_cnt = 0; first_aw_cyc = -1; aw_pend = 0;
    src0 = src_idx;
    model(a, size);
    fdma_waddr = a; fdma_wsize = 16'(size); fdma_wareq = 1'b1;
    @(posedge ui_clk);
    #1;
    fdma_wareq = 1'b0;
    fdma_waddr = $urandom; fdma_wsize = 16'($urandom);
  endtask

  task automatic run_xfer(input logic [31:0] a, input int size, input bit poke);
    bit done = 0;
    start(a, size);
    for (int i = 0; i < 20000; i++) begin
      @(negedge ui_clk);
      #1;
      if (poke && i == 20) begin
        fdma_wareq = 1'b1; fdma_waddr = 32'h7777_0000; fdma_wsize = 16'd5;
      end
      if (i == 21) fdma_wareq = 1'b0;
      if (!fdma_wbusy) begin
        done = 1;
        idle_cyc = cyc;
        break;
      end
    end
    total++;
    if (!done) $display("FAIL xfer_timeout: busy still %b after 20000 cycles, expected 0", fdma_wbusy);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ui_clk);
    #1;
    total++;
    if ({fdma_wbusy, fdma_wvalid, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, wr_err,
         m_axi_awaddr, m_axi_awlen} !== '0)
      $display("FAIL reset_outputs: got %b/%h/%h expected all zero",
               {fdma_wbusy, fdma_wvalid, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, wr_err},
               m_axi_awaddr, m_axi_awlen);
    else passed++;
    total++;
    if ({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_wstrb} !== {4'd0, 3'd4, 2'b01, 16'hFFFF})
      $display("FAIL const_outputs: got id=%h size=%h burst=%h strb=%h expected 0/4/1/ffff",
               m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_wstrb);
    else passed++;
    ui_rstn = 1'b1;
  endtask

  task automatic test_single();
    rnd = 0; err_idx = -1;
    run_xfer(32'h0000_0000, 240, 0);
    total++;
    if (bursts_bad() != 0 || aw_q.size() != 1 || aw_q[0] !== {32'h0, 8'd239})
      $display("FAIL single_burst: got %0d bursts first %h expected 1 burst %h", aw_q.size(), aw_q[0], {32'h0, 8'd239});
    else passed++;
    total++;
    if (pop_q.size() != 240) $display("FAIL single_pops: got %0d expected 240", pop_q.size());
    else passed++;
    total++;
    if (data_bad() != 0) $display("FAIL single_data: got %0d bad beats expected 0", data_bad());
    else passed++;
    total++;
    if (wlast_bad() != 0 || wlast_q.size() != 1 || wlast_q[0] != 239)
      $display("FAIL single_wlast: got %0d wlast, first at %0d expected 1 at 239", wlast_q.size(), wlast_q[0]);
    else passed++;
    total++;
    if (first_aw_cyc - req_cyc != 2) $display("FAIL req_to_aw: got %0d cycles expected 2", first_aw_cyc - req_cyc);
    else passed++;
    total++;
    if (idle_cyc - b_last_cyc != 1) $display("FAIL b_to_idle: got %0d cycles expected 1", idle_cyc - b_last_cyc);
    else passed++;
    total++;
    if (viol != 0) $display("FAIL single_protocol: got %0d violations expected 0", viol);
    else passed++;
  endtask

  task automatic test_multi();
    rnd = 1; err_idx = -1;
    run_xfer(32'h1000_0000, 600, 1);
    total++;
    if (bursts_bad() != 0 || aw_q.size() != 3 || aw_q[1] !== {32'h1000_1000, 8'd255} || aw_q[2] !== {32'h1000_2000, 8'd87})
      $display("FAIL multi_bursts: got %0d bursts last %h expected 3 bursts last %h", aw_q.size(), aw_q[2], {32'h1000_2000, 8'd87});
    else passed++;
    total++;
    if (pop_q.size() != 600) $display("FAIL multi_pops: got %0d expected 600 (second wareq must be ignored)", pop_q.size());
    else passed++;
    total++;
    if (data_bad() != 0 || wlast_bad() != 0) $display("FAIL multi_data: got %0d/%0d bad data/wlast expected 0/0", data_bad(), wlast_bad());
    else passed++;
    total++;
    if (viol != 0 || wr_err !== 1'b0) $display("FAIL multi_protocol: got viol=%0d wr_err=%b expected 0/0", viol, wr_err);
    else passed++;
  endtask

  task automatic test_4k();
    logic [7:0] first_len;
`ifdef FDMA_W_4K_SPLIT_EN
    first_len = 8'd15;
`else
    first_len = 8'd255;
`endif
    rnd = 0; err_idx = -1;
    run_xfer(32'h0000_0F00, 256, 0);
    total++;
    if (bursts_bad() != 0 || aw_q[0] !== {32'h0000_0F00, first_len})
      $display("FAIL split_4k: got %0d bursts first %h expected first %h", aw_q.size(), aw_q[0], {32'h0000_0F00, first_len});
    else passed++;
    total++;
    if (pop_q.size() != 256 || wlast_bad() != 0) $display("FAIL split_4k_pops: got %0d pops expected 256", pop_q.size());
    else passed++;
  endtask

  task automatic test_random();
    rnd = 1; err_idx = -1;
    repeat (3) begin
      logic [31:0] a = $urandom;
      int size = $urandom_range(1, 700);
      run_xfer(a, size, 0);
      total++;
      if (bursts_bad() != 0) $display("FAIL rand_bursts: addr %h size %0d got %0d bursts expected %0d", a, size, aw_q.size(), exp_q.size());
      else passed++;
      total++;
      if (pop_q.size() != size) $display("FAIL rand_pops: got %0d expected %0d", pop_q.size(), size);
      else passed++;
      total++;
      if (data_bad() != 0 || wlast_bad() != 0) $display("FAIL rand_data: got %0d/%0d bad data/wlast expected 0/0", data_bad(), wlast_bad());
      else passed++;
      total++;
      if (viol != 0) $display("FAIL rand_protocol: got %0d violations expected 0", viol);
      else passed++;
    end
  endtask

  task automatic test_bresp();
    rnd = 1; err_idx = 1;
    run_xfer(32'h2000_0000, 600, 0);
    total++;
    if (aw_q.size() != 3 || bursts_bad() != 0) $display("FAIL err_bursts: got %0d bursts expected 3", aw_q.size());
    else passed++;
    total++;
    if (wr_err !== 1'b1) $display("FAIL err_set: got wr_err=%b expected 1", wr_err);
    else passed++;
    err_idx = -1;
    run_xfer(32'h0000_0040, 1, 0);
    total++;
    if (wr_err !== 1'b1 || aw_q.size() != 1 || aw_q[0] !== {32'h40, 8'd0})
      $display("FAIL err_sticky: got wr_err=%b burst %h expected 1 and %h", wr_err, aw_q[0], {32'h40, 8'd0});
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    rnd = 0; err_idx = -1;
    start(32'h0000_0000, 240);
    for (int i = 0; i < 2000; i++) begin
      @(negedge ui_clk);
      #1;
      if (pop_q.size() >= 100) begin
        hit = 1;
        break;
      end
    end
    total++;
    if (!hit) $display("FAIL reset_mid_wait: got %0d pops expected 100", pop_q.size());
    else passed++;
    @(posedge ui_clk);
    #3;
    ui_rstn = 1'b0;
    #1;
    total++;
    if ({fdma_wbusy, fdma_wvalid, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, wr_err,
         m_axi_awaddr, m_axi_awlen} !== '0)
      $display("FAIL reset_mid_outputs: got %b/%h/%h expected all zero",
               {fdma_wbusy, fdma_wvalid, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, wr_err},
               m_axi_awaddr, m_axi_awlen);
    else passed++;
    repeat (3) @(negedge ui_clk);
    ui_rstn = 1'b1;
    run_xfer(32'h0000_0080, 0, 0);
    total++;
    if (busy_cnt != 1 || aw_hs != 0 || pop_q.size() != 0)
      $display("FAIL size_zero: got busy %0d cycles, %0d aw, %0d pops expected 1/0/0", busy_cnt, aw_hs, pop_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_4k();
    test_random();
    test_bresp();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
